// File: rtl/linear_layer_fifo_pkg.sv
// Shared definitions for the linear-layer dataflow FIFOs: default start-FIFO
// geometry, the occupancy type and a constant-foldable clog2 helper.
package linear_layer_fifo_pkg;

  localparam int unsigned START_FIFO_DATA_WIDTH = 1;
  localparam int unsigned START_FIFO_ADDR_WIDTH = 1;
  localparam int unsigned START_FIFO_DEPTH      = 2;

  // Occupancy is one bit wider than the address so a completely full FIFO is representable.
  typedef logic [START_FIFO_ADDR_WIDTH:0] cnt_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/linear_layer_token_srl.sv
// Enable-gated shift-register storage with a combinational read port.
// Deliberately reset-free so it maps onto SRL primitives.
module linear_layer_token_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/linear_layer_start_token_fifo.sv
// Start-token FIFO controller: occupancy, registered full/empty flags and the
// read address into the shift-register storage (oldest entry at count-1).
module linear_layer_start_token_fifo
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = START_FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = START_FIFO_ADDR_WIDTH,
  parameter int DEPTH      = START_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_n_q, empty_n_q;
  logic                  wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] raddr;

  assign wr_acc = if_write & if_write_ce & full_n_q;
  assign rd_acc = if_read  & if_read_ce  & empty_n_q;

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // At count == DEPTH == 2**ADDR_WIDTH the low bits wrap to zero, so subtracting one still lands on DEPTH-1.
  always_comb begin
    raddr = '0;
    if (count_q != '0) begin
      raddr = count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      count_q   <= count_d;
      empty_n_q <= (count_d != '0);
      full_n_q  <= (count_d != CNT_DEPTH);
    end
  end

  linear_layer_token_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk  (clk),
    .we   (wr_acc),
    .addr (raddr),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;
  assign if_fifo_cap       = CNT_DEPTH;

endmodule

// File: doc/linear_layer_start_token_fifo.md
# linear_layer_start_token_fifo

Shift-register FIFO that carries start tokens (and optional small payloads) between dataflow processes in the linear-layer datapath, e.g. from the tile dispatcher to a PE instance. It owns occupancy tracking, full/empty flags and the read pointer. Storage is a separate enable-gated shift register with a combinational read address. Writes shift into slot 0; the oldest entry is read at index `count-1`.

## Interface
- `DATA_WIDTH`, 1, token payload width in bits (1 for a pure start token).
- `ADDR_WIDTH`, 1, storage address width; `2**ADDR_WIDTH >= DEPTH`.
- `DEPTH`, 2, entry capacity; legal range 1..`2**ADDR_WIDTH`.
- Reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `if_write_ce`  in  1  write-side clock enable; gates `if_write`.
- `if_write`  in  1  producer write request.
- `if_din`  in  DATA_WIDTH  write data.
- `if_full_n`  out  1  registered; 1 = space available.
- `if_read_ce`  in  1  read-side clock enable; gates `if_read`.
- `if_read`  in  1  consumer read request.
- `if_dout`  out  DATA_WIDTH  oldest entry; combinational from storage.
- `if_empty_n`  out  1  registered; 1 = `if_dout` holds valid data.
- `if_num_data_valid`  out  ADDR_WIDTH+1  current occupancy.
- `if_fifo_cap`  out  ADDR_WIDTH+1  constant `DEPTH`.

## Operation
- `wr_acc` = `if_write & if_write_ce & if_full_n`.
- `rd_acc` = `if_read & if_read_ce & if_empty_n`.
- Requests made while the corresponding flag is low are ignored. They are not errors and cause no state change.
- On `wr_acc`, storage shifts by one and `if_din` enters slot 0.
- Read address is `count-1` (0 when `count` = 0). The storage sub-module takes `ADDR_WIDTH` bits.
- Count update:
  - `wr_acc` only: `count+1`.
  - `rd_acc` only: `count-1`.
  - Both or neither: unchanged.
- Flag update at each edge, from the next count:
  - `if_empty_n` = (next count != 0).
  - `if_full_n` = (next count != DEPTH).
- `if_num_data_valid` = `count`. Width is `ADDR_WIDTH+1`, so `DEPTH` = `2**ADDR_WIDTH` never wraps.
- Simultaneous read+write when 0 < count < DEPTH:
  - The shift moves the old entries up one slot, and the address stays at `count-1`.
  - The next-oldest entry therefore appears on `if_dout`.
  - Both flags are unchanged.
- Full (`if_full_n` = 0) with write and read in the same cycle: only the read is accepted. Next count is DEPTH-1 and `if_full_n` rises.
- Empty with write and read in the same cycle: only the write is accepted. There is no fall-through bypass.
- DEPTH = 1:
  - `if_full_n` and `if_empty_n` are complementary.
  - The FIFO alternates strictly between one write and one read.
- Reset values: `count` = 0, `if_empty_n` = 0, `if_full_n` = 1, `if_num_data_valid` = 0.
- Storage contents are not reset, so `if_dout` is undefined while empty.
- Reset asserted mid-operation discards all entries immediately and asynchronously. The first edge after deassertion accepts writes.

## Timing
- Write-to-read latency is 1 cycle. A write accepted at edge *t* raises `if_empty_n` after *t*, and `if_dout` is valid in the same cycle.
- The consumer may read at edge *t+1*.
- After the write that fills the FIFO, `if_full_n` falls in the following cycle. It is never combinationally dependent on `if_read`.
- After the read that frees the first slot, `if_full_n` rises in the following cycle.
- With count at 1..DEPTH-1, sustained throughput is 1 token/cycle.
- There are no combinational paths from inputs to `if_full_n`, `if_empty_n` or `if_num_data_valid`.

## Structure
- Shared package `linear_layer_fifo_pkg` holds:
  - `clog2` function.
  - Occupancy typedef `cnt_t` (`ADDR_WIDTH+1` bits).
  - Default depth constants for start FIFOs.
- One sub-module, `linear_layer_token_srl`:
  - Ports: `clk`, `we`, `addr`, `din`, `dout`.
  - No reset, so it maps to SRL primitives.
- The controller contains only the count, flag and address logic.

## Test plan
- Reset, then write 4'hA at cycle 1 -> `if_empty_n` = 1 and `if_dout` = 4'hA in cycle 2; `if_num_data_valid` = 1.
- DEPTH=2: write 4'h1 then 4'h2 -> `if_full_n` = 0 after the second edge. A third write of 4'h3 is ignored. Reads return 1, then 2, then `if_empty_n` = 0.
- Count=1 holding 4'h5, simultaneous write 4'h6 and read -> 5 consumed, `if_dout` = 6 next cycle, both flags unchanged.
- Full with simultaneous read and write -> only the read is accepted, count = DEPTH-1, `if_full_n` = 1 next cycle. Empty with simultaneous read and write -> only the write is accepted, count = 1.
- `if_write` = 1 with `if_write_ce` = 0, and `if_read` = 1 with `if_read_ce` = 0 -> no state change for 3 cycles.
- Fill to 2 entries, pulse `reset_n` low mid-cycle -> flags reach 0/1 and count reaches 0 asynchronously before the next edge. A write immediately after deassertion is accepted.
